// File: rtl/alu_req_sched_if.sv
// Request, response and ALU-side bus of the two-requester ALU scheduler.
// The scheduler connects through the slave modport; clients and the ALU use master.
interface alu_req_sched_if #(
  parameter int WIDTH = 16
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [7:0]         req_op;

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [3:0]         alu_op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               alu_zero;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_carry;
  logic               rsp_zero;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  alu_result, alu_carry, alu_zero,
    input  rsp_ready,
    output req_ready,
    output alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    output alu_result, alu_carry, alu_zero,
    output rsp_ready,
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one combinational ALU between two requesters,
// holding operands for ALU_LAT cycles and returning a tagged, backpressured response.
module alu_req_sched #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  alu_req_sched_if.slave      bus,
  output logic                o_busy,
  output logic [15:0]         o_done_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

  state_t           r_state;
  logic             r_lastGrant;
  logic [3:0]       r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [3:0]       r_aluOp;
  logic             r_rspValid;
  logic             r_rspId;
  logic [WIDTH-1:0] r_rspData;
  logic             r_rspCarry;
  logic             r_rspZero;
  logic             r_rspErr;
  logic [15:0]      r_doneCount;

  logic             w_grant;
  logic [1:0]       w_reqReady;
  logic             w_accept;
  logic [WIDTH-1:0] w_laneA;
  logic [WIDTH-1:0] w_laneB;
  logic [3:0]       w_laneOp;
  logic             w_legal;

  function automatic logic isLegal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100, 4'b0110, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1100,
      4'b1101, 4'b1110, 4'b1111: isLegal = 1'b1;
      default:                   isLegal = 1'b0;
    endcase
  endfunction

  // On a tie the requester that was not served last wins; ready is held low during reset.
  always_comb begin
    w_grant    = (bus.req_valid == 2'b11) ? ~r_lastGrant : bus.req_valid[1];
    w_reqReady = 2'b00;
    if (r_state == IDLE && i_rst_n) begin
      w_reqReady = w_grant ? {bus.req_valid[1], 1'b0} : {1'b0, bus.req_valid[0]};
    end
    w_accept = |w_reqReady;
    w_laneA  = w_grant ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
    w_laneB  = w_grant ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
    w_laneOp = w_grant ? bus.req_op[4 +: 4] : bus.req_op[0 +: 4];
    w_legal  = isLegal(w_laneOp);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_cnt       <= '0;
      r_op        <= '0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluOp     <= '0;
      r_rspValid  <= 1'b0;
      r_rspId     <= 1'b0;
      r_rspData   <= '0;
      r_rspCarry  <= 1'b0;
      r_rspZero   <= 1'b0;
      r_rspErr    <= 1'b0;
      r_doneCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= w_laneOp;
            r_rspId <= w_grant;
            if (w_legal) begin
              r_state <= ISSUE;
              r_cnt   <= LAT_LOAD;
              r_aluA  <= w_laneA;
              r_aluB  <= w_laneB;
              r_aluOp <= w_laneOp;
            end else begin
              // Illegal opcodes never reach the ALU and are answered immediately.
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspData  <= '0;
              r_rspCarry <= 1'b0;
              r_rspZero  <= 1'b1;
              r_rspErr   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (r_cnt == 4'd0) begin
            r_rspData  <= bus.alu_result;
            r_rspZero  <= bus.alu_zero;
            r_rspCarry <= (r_op == 4'b0000) ? bus.alu_carry : 1'b0;
            r_rspErr   <= 1'b0;
            r_rspValid <= 1'b1;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_aluOp    <= '0;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rspValid  <= 1'b0;
            r_lastGrant <= r_rspId;
            r_doneCount <= r_doneCount + 16'd1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.alu_a     = r_aluA;
  assign bus.alu_b     = r_aluB;
  assign bus.alu_op    = r_aluOp;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_id    = r_rspId;
  assign bus.rsp_data  = r_rspData;
  assign bus.rsp_carry = r_rspCarry;
  assign bus.rsp_zero  = r_rspZero;
  assign bus.rsp_err   = r_rspErr;
  assign o_busy        = (r_state != IDLE);
  assign o_done_count  = r_doneCount;

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched: one instance with ALU_LAT=1 for the main
// scenarios and one with ALU_LAT=3 for the operand hold time, each with an ALU model.
module tb_alu_req_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic        busyA, busyB;
  logic [15:0] doneA, doneB;
  logic [16:0] aluOutA, aluOutB;

  always #5 clk = ~clk;

  alu_req_sched_if #(.WIDTH(16)) ifA ();
  alu_req_sched_if #(.WIDTH(16)) ifB ();

  alu_req_sched #(.WIDTH(16), .ALU_LAT(1)) dutA (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifA), .o_busy(busyA), .o_done_count(doneA)
  );

  alu_req_sched #(.WIDTH(16), .ALU_LAT(3)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifB), .o_busy(busyB), .o_done_count(doneB)
  );

  // Reference ALU: {carry, result}; sub reports carry as "no borrow".
  function automatic logic [16:0] aluModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    r = '0;
    case (op)
      4'b0000: r = {1'b0, a} + {1'b0, b};
      4'b0100: r[15:0] = a ^ b;
      4'b0110: r[15:0] = a | b;
      4'b0111: r[15:0] = a & b;
      4'b1000: r[0] = (a == b);
      4'b1001: r[0] = (a != b);
      4'b1010: r = {1'b0, a} + {1'b0, ~b} + 17'd1;
      4'b1100: r[0] = ($signed(a) < $signed(b));
      4'b1101: r[0] = ($signed(a) >= $signed(b));
      4'b1110: r[0] = (a < b);
      4'b1111: r[0] = (a >= b);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign aluOutA        = aluModel(ifA.alu_op, ifA.alu_a, ifA.alu_b);
  assign ifA.alu_result = aluOutA[15:0];
  assign ifA.alu_carry  = aluOutA[16];
  assign ifA.alu_zero   = (aluOutA[15:0] == 16'h0000);
  assign aluOutB        = aluModel(ifB.alu_op, ifB.alu_a, ifB.alu_b);
  assign ifB.alu_result = aluOutB[15:0];
  assign ifB.alu_carry  = aluOutB[16];
  assign ifB.alu_zero   = (aluOutB[15:0] == 16'h0000);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] op0,
                               input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] op1);
    ifA.req_valid = valid;
    ifA.req_a     = {a1, a0};
    ifA.req_b     = {b1, b0};
    ifA.req_op    = {op1, op0};
  endtask

  // One request on a single lane with rsp_ready high; checks latency and response fields.
  task automatic runOp(input string tag, input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input int expLat, input logic [15:0] expData,
                       input logic expCarry, input logic expZero, input logic expErr);
    int         lat;
    logic [3:0] opSeen;
    @(negedge clk);
    if (id) applyStimulus(2'b10, 16'h0, 16'h0, 4'h0, a, b, op);
    else    applyStimulus(2'b01, a, b, op, 16'h0, 16'h0, 4'h0);
    ifA.rsp_ready = 1'b1;
    #1;
    checkOutput({tag, "_ready"}, ifA.req_ready, id ? 2'b10 : 2'b01);
    lat    = 0;
    opSeen = 4'h0;
    while (!ifA.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) ifA.req_valid = 2'b00;
      #1;
      opSeen = opSeen | ifA.alu_op;
    end
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_id"}, ifA.rsp_id, id);
    checkOutput({tag, "_data"}, ifA.rsp_data, expData);
    checkOutput({tag, "_carry"}, ifA.rsp_carry, expCarry);
    checkOutput({tag, "_zero"}, ifA.rsp_zero, expZero);
    checkOutput({tag, "_err"}, ifA.rsp_err, expErr);
    checkOutput({tag, "_aluop"}, opSeen, expErr ? 4'h0 : op);
    @(negedge clk);
    #1;
    checkOutput({tag, "_drop"}, ifA.rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         got;
    int         holdCnt;
    int         lat;
    logic       seen;

    applyStimulus(2'b11, 16'h1, 16'h2, 4'h0, 16'h3, 16'h4, 4'h0);
    ifA.rsp_ready = 1'b0;
    ifB.req_valid = 2'b00;
    ifB.req_a     = '0;
    ifB.req_b     = '0;
    ifB.req_op    = '0;
    ifB.rsp_ready = 1'b0;

    // Reset values, with both requesters already asserting valid
    #12;
    checkOutput("rst_ready", ifA.req_ready, 2'b00);
    checkOutput("rst_busy", busyA, 1'b0);
    checkOutput("rst_done", doneA, 16'h0);
    checkOutput("rst_aluop", ifA.alu_op, 4'h0);
    checkOutput("rst_alua", ifA.alu_a, 16'h0);
    checkOutput("rst_rspvalid", ifA.rsp_valid, 1'b0);
    checkOutput("rst_rspzero", ifA.rsp_zero, 1'b0);
    checkOutput("rst_rsperr", ifA.rsp_err, 1'b0);
    ifA.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Add with carry out and zero result
    runOp("add", 1'b0, 16'hFFFF, 16'h0001, 4'b0000, 2, 16'h0000, 1'b1, 1'b1, 1'b0);
    checkOutput("add_done", doneA, 16'd1);

    // Illegal opcode from requester 1
    runOp("illegal", 1'b1, 16'h1234, 16'h5678, 4'b0010, 1, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Both requesters valid continuously: strict alternation starting with 0
    @(negedge clk);
    applyStimulus(2'b11, 16'h00FF, 16'h0F0F, 4'b0100, 16'h1200, 16'h0034, 4'b0110);
    ifA.rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      #1;
      checkOutput("rr_onehot", (ifA.req_ready == 2'b11), 1'b0);
      if (ifA.rsp_valid) begin
        checkOutput("rr_id", ifA.rsp_id, got % 2);
        checkOutput("rr_data", ifA.rsp_data, (got % 2 == 1) ? 16'h1234 : 16'h0FF0);
        got++;
        if (got == 4) ifA.req_valid = 2'b00;
      end
      @(negedge clk);
    end
    checkOutput("rr_count", got, 4);
    #1;
    checkOutput("rr_done", doneA, 16'd6);

    // Backpressure: response held while rsp_ready is low
    @(negedge clk);
    applyStimulus(2'b01, 16'h0005, 16'h0003, 4'b1010, 16'h0, 16'h0, 4'h0);
    ifA.rsp_ready = 1'b0;
    #1;
    checkOutput("bp_accept", ifA.req_ready, 2'b01);
    @(negedge clk);
    applyStimulus(2'b10, 16'h0, 16'h0, 4'h0, 16'h0001, 16'h0001, 4'b0000);
    #1;
    checkOutput("bp_issue_ready", ifA.req_ready, 2'b00);
    checkOutput("bp_issue_busy", busyA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_valid", ifA.rsp_valid, 1'b1);
      checkOutput("bp_data", ifA.rsp_data, 16'h0002);
      checkOutput("bp_carry", ifA.rsp_carry, 1'b0);
      checkOutput("bp_ready", ifA.req_ready, 2'b00);
      checkOutput("bp_busy", busyA, 1'b1);
    end
    ifA.req_valid = 2'b00;
    ifA.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("bp_drop", ifA.rsp_valid, 1'b0);
    checkOutput("bp_done", doneA, 16'd7);
    checkOutput("bp_idle", busyA, 1'b0);

    // Signed versus unsigned compare with the same operands
    runOp("slt", 1'b0, 16'h8000, 16'h0001, 4'b1100, 2, 16'h0001, 1'b0, 1'b0, 1'b0);
    runOp("sltu", 1'b0, 16'h8000, 16'h0001, 4'b1110, 2, 16'h0000, 1'b0, 1'b1, 1'b0);

    // ALU_LAT=3 instance: opcode held exactly three cycles
    @(negedge clk);
    ifB.req_valid = 2'b01;
    ifB.req_a     = {16'h0, 16'h8000};
    ifB.req_b     = {16'h0, 16'h0001};
    ifB.req_op    = {4'h0, 4'b1100};
    ifB.rsp_ready = 1'b1;
    #1;
    checkOutput("lat3_accept", ifB.req_ready, 2'b01);
    holdCnt = 0;
    lat     = 0;
    seen    = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 1) ifB.req_valid = 2'b00;
      #1;
      if (ifB.alu_op == 4'b1100) holdCnt++;
      if (ifB.rsp_valid && !seen) begin
        seen = 1'b1;
        lat  = cyc;
        checkOutput("lat3_data", ifB.rsp_data, 16'h0001);
      end
    end
    checkOutput("lat3_seen", seen, 1'b1);
    checkOutput("lat3_hold", holdCnt, 3);
    checkOutput("lat3_lat", lat, 4);
    checkOutput("lat3_done", doneB, 16'd1);

    // Reset during ISSUE drops the operation; requester 0 wins the first tie afterwards
    @(negedge clk);
    applyStimulus(2'b11, 16'h00FF, 16'h0F0F, 4'b0100, 16'h1111, 16'h1111, 4'b0000);
    ifA.rsp_ready = 1'b1;
    #1;
    checkOutput("mid_grant", ifA.req_ready, 2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_aluop", ifA.alu_op, 4'h0);
    checkOutput("mid_alua", ifA.alu_a, 16'h0);
    checkOutput("mid_busy", busyA, 1'b0);
    checkOutput("mid_rspvalid", ifA.rsp_valid, 1'b0);
    checkOutput("mid_ready", ifA.req_ready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_grant", ifA.req_ready, 2'b01);
    checkOutput("post_done", doneA, 16'h0);
    @(negedge clk);
    ifA.req_valid = 2'b00;
    lat = 0;
    while (!ifA.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      #1;
    end
    checkOutput("post_valid", ifA.rsp_valid, 1'b1);
    checkOutput("post_id", ifA.rsp_id, 1'b0);
    checkOutput("post_data", ifA.rsp_data, 16'h0FF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
